updown_step_ctrl: RTL and testbench
===================================

// Module: updown_step_ctrl
// PURPOSE
//  Controller that sequences the board's 16-bit display counter from two active-low push buttons.
//  - Synchronises and debounces the up and down buttons.
//  - Issues single steps, then auto-repeat steps while a button is held.
//  - Owns the counter register that feeds the 7-segment driver.
//  - Raises a click request that gates the Beep tone generator.
//  Sits between the btn[] pins and the LED7Seg/Beep instances in top.
// PARAMETERS
//  WIDTH           16          counter width
//  INIT            16'h05ec    counter value after reset
//  DEBOUNCE_CYCLES 1_000_000   cycles a raw level must stay stable to be accepted (20 ms @ 50 MHz)
//  REPEAT_DELAY    25_000_000  hold time from first step to first auto-repeat step (500 ms)
//  REPEAT_PERIOD   5_000_000   interval between auto-repeat steps (100 ms)
//  CLICK_CYCLES    2_500_000   click pulse length per step (50 ms)
// PORTS
//  clk       in   1      system clock, 50 MHz
//  reset     in   1      asynchronous reset, active-low (0: reset asserted)
//  btn_up_n  in   1      raw up button, 0 = pushed, asynchronous to clk
//  btn_dn_n  in   1      raw down button, 0 = pushed, asynchronous to clk
//  step_up   out  1      one-cycle pulse when counter increments
//  step_dn   out  1      one-cycle pulse when counter decrements
//  count     out  WIDTH  current counter value
//  click     out  1      1 while beep requested; drives Beep enable
// BEHAVIOUR
//  Reset (reset==0, async):
//   - count=INIT; step_up=step_dn=click=0; FSM=IDLE; all timers 0.
//   - Debounced state = released.
//   - Takes effect immediately mid-press or mid-repeat; after release, a still-held button is
//     treated as a new press once debounced.
//  Input path: each raw input passes a 2-FF synchroniser, then the debouncer.
//   - Debounced level updates only after the synchronised level differs from it for
//     DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
//   - Clean press to step_up/step_dn pulse latency: exactly DEBOUNCE_CYCLES+3 cycles.
//  up = debounced up pressed, dn = debounced down pressed. FSM, all transitions on posedge clk:
//   IDLE:   up&~dn -> step up, DELAY(dir=up); dn&~up -> step down, DELAY(dir=dn);
//           up&dn -> BLOCK; else stay.
//   DELAY:  timer counts REPEAT_DELAY cycles.
//           Expiry -> step in dir, REPEAT.
//           Active button released -> IDLE. Other button pressed -> BLOCK.
//   REPEAT: step in dir every REPEAT_PERIOD cycles.
//           Active button released -> IDLE. Other button pressed -> BLOCK.
//   BLOCK:  no steps; stay until ~up&~dn, then IDLE. A press held from BLOCK never steps.
//  Steps:
//   - step_up/step_dn high one cycle; count updates on the same edge the pulse asserts.
//   - Arithmetic modulo 2^WIDTH: all-ones+1 -> 0, 0-1 -> all-ones.
//   - step_up and step_dn are never high in the same cycle.
//  Click:
//   - Asserts on the edge of each step and holds CLICK_CYCLES cycles.
//   - A new step while click is high restarts the full length.
//   - If REPEAT_PERIOD<=CLICK_CYCLES, click stays continuously high during repeat.
//  Timers saturate-free: widths sized by $clog2 of their parameter, reset to 0 on every state entry.
// STRUCTURE
//  Shared include/package:
//   - FSM state encodings IDLE/DELAY/REPEAT/BLOCK (2-bit localparams).
//   - Dir encoding.
//   - Default timing constants at 50 MHz, also used by top and the bench.
//  Sub-module btn_debounce(clk, reset, raw_n, pressed):
//   - 2-FF synchroniser plus stability counter, DEBOUNCE_CYCLES parameter.
//   - Instantiated twice.
//  Top-level body: FSM, delay/period timer, counter register, click timer.
// TESTING (sim params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, CLICK_CYCLES=3, INIT=16'h05ec)
//  1. Reset release, no buttons, 100 cycles -> count=16'h05ec, step_*=0, click=0 throughout.
//  2. btn_up_n low 10 cycles then high -> one step_up exactly 7 cycles after fall; count=16'h05ed;
//     click high 3 cycles; no repeat.
//  3. btn_up_n bouncing 1-0-1-0 at 2-cycle intervals then stable low ->
//     single step_up 7 cycles after final fall.
//  4. btn_dn_n held 60 cycles -> steps at t, t+20, t+25, t+30, ...; count decrements per step;
//     release -> no further steps.
//  5. INIT=16'hffff, one up press -> count=16'h0000.
//     INIT=16'h0000, one down press -> count=16'hffff.
//  6. Hold up into REPEAT, then press down -> steps stop within 1 cycle of dn debounce.
//     Release up only -> still no steps. Release both, press up -> normal single step.
//     Additionally: assert reset mid-REPEAT -> count=INIT and click=0 immediately.

Source files
------------

// File: rtl/updown_step_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// updown_step_ctrl_pkg
//   Shared definitions for the up/down step controller:
//     - state_t : controller FSM state encodings (2-bit)
//     - dir_t   : active step direction
//     - DEF_*   : default timing constants for a 50 MHz system clock
//     - cnt_width() : width helper for cycle counters
// ----------------------------------------------------------------------------
package updown_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_BLOCK  = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    localparam int          DEF_WIDTH           = 16;
    localparam logic [15:0] DEF_INIT            = 16'h05ec;
    localparam int          DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms
    localparam int          DEF_REPEAT_DELAY    = 25_000_000; // 500 ms
    localparam int          DEF_REPEAT_PERIOD   = 5_000_000;  // 100 ms
    localparam int          DEF_CLICK_CYCLES    = 2_500_000;  // 50 ms

    // Width of a counter that only ever holds 0 .. n-1. Never narrower than
    // one bit so that degenerate parameter values still elaborate.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/updown_step_ctrl_btn_debounce.sv
// ----------------------------------------------------------------------------
// updown_step_ctrl_btn_debounce
//   Brings one raw, asynchronous, active-low push button into the clock
//   domain and debounces it.
//
//   Ports
//     clk      in  1  system clock
//     reset    in  1  asynchronous reset, active-low
//     raw_n    in  1  raw button level, 0 = pushed, asynchronous to clk
//     pressed  out 1  debounced level, 1 = pushed
//
//   The debounced level changes only after the synchronised level has
//   disagreed with it for DEBOUNCE_CYCLES consecutive cycles; a single
//   cycle of agreement restarts the count. Synchroniser (2 cycles) plus
//   the stability count give a press-to-pressed latency of
//   DEBOUNCE_CYCLES + 2 cycles.
// ----------------------------------------------------------------------------
module updown_step_ctrl_btn_debounce
    import updown_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic pressed
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_pressed;
    logic [CW-1:0] r_cnt;
    logic          w_level;
    logic          w_differs;

    // Synchroniser resets to "released" so a button held through reset is
    // seen as a fresh press once reset is removed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= raw_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_level   = ~r_sync2;
    assign w_differs = (w_level != r_pressed);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pressed <= 1'b0;
            r_cnt     <= '0;
        end else if (w_differs) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_pressed <= w_level;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign pressed = r_pressed;

endmodule

// File: rtl/updown_step_ctrl.sv
// ----------------------------------------------------------------------------
// updown_step_ctrl
//   Sequences the board's display counter from two active-low push buttons:
//   debounces both buttons, issues a single step on press, then auto-repeat
//   steps while the button stays held, and requests a click tone per step.
//
//   Ports
//     clk        in  1      system clock (50 MHz)
//     reset      in  1      asynchronous reset, active-low
//     btn_up_n   in  1      raw up button, 0 = pushed, asynchronous
//     btn_dn_n   in  1      raw down button, 0 = pushed, asynchronous
//     step_up    out 1      one-cycle pulse on the edge count increments
//     step_dn    out 1      one-cycle pulse on the edge count decrements
//     count      out WIDTH  counter value feeding the 7-segment driver
//     click      out 1      beep request, high CLICK_CYCLES after each step
//     dbg_state  out 2      current controller state
//
//   State machine
//     IDLE   : single press -> step, DELAY; both pressed -> BLOCK
//     DELAY  : wait REPEAT_DELAY cycles, then step and enter REPEAT
//     REPEAT : step every REPEAT_PERIOD cycles
//     BLOCK  : no stepping until both buttons are released
//   In DELAY/REPEAT, pressing the other button wins over releasing the
//   active one and over a timer expiry in the same cycle.
// ----------------------------------------------------------------------------
module updown_step_ctrl
    import updown_step_ctrl_pkg::*;
#(
    parameter int               WIDTH           = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT            = DEF_INIT,
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int               REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int               CLICK_CYCLES    = DEF_CLICK_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up_n,
    input  logic             btn_dn_n,
    output logic             step_up,
    output logic             step_dn,
    output logic [WIDTH-1:0] count,
    output logic             click,
    output state_t           dbg_state
);

    // One timer serves both DELAY and REPEAT, so it is sized for the larger.
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                            : REPEAT_PERIOD;
    localparam int TW      = cnt_width(TMR_MAX);
    localparam int KW      = cnt_width(CLICK_CYCLES);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_up;
    logic w_dn;

    updown_step_ctrl_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clk     (clk),
        .reset   (reset),
        .raw_n   (btn_up_n),
        .pressed (w_up)
    );

    updown_step_ctrl_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_dn (
        .clk     (clk),
        .reset   (reset),
        .raw_n   (btn_dn_n),
        .pressed (w_dn)
    );

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    state_t           r_state;
    dir_t             r_dir;
    logic [TW-1:0]    r_timer;
    logic             r_step_up;
    logic             r_step_dn;
    logic [WIDTH-1:0] r_count;
    logic             r_click;
    logic [KW-1:0]    r_click_cnt;

    state_t           w_state_nxt;
    dir_t             w_dir_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic             w_step_up;
    logic             w_step_dn;
    logic             w_active;
    logic             w_other;
    logic             w_step_any;

    // Button that owns the current press, and the opposing one.
    assign w_active = (r_dir == DIR_UP) ? w_up : w_dn;
    assign w_other  = (r_dir == DIR_UP) ? w_dn : w_up;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_UP;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_timer_nxt = '0;
        w_step_up   = 1'b0;
        w_step_dn   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_up && w_dn) begin
                    w_state_nxt = ST_BLOCK;
                end else if (w_up) begin
                    w_step_up   = 1'b1;
                    w_dir_nxt   = DIR_UP;
                    w_state_nxt = ST_DELAY;
                end else if (w_dn) begin
                    w_step_dn   = 1'b1;
                    w_dir_nxt   = DIR_DN;
                    w_state_nxt = ST_DELAY;
                end
            end

            ST_DELAY: begin
                if (w_other) begin
                    w_state_nxt = ST_BLOCK;
                end else if (!w_active) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == TW'(REPEAT_DELAY - 1)) begin
                    w_step_up   = (r_dir == DIR_UP);
                    w_step_dn   = (r_dir == DIR_DN);
                    w_state_nxt = ST_REPEAT;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            ST_REPEAT: begin
                if (w_other) begin
                    w_state_nxt = ST_BLOCK;
                end else if (!w_active) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == TW'(REPEAT_PERIOD - 1)) begin
                    // Timer restarts from 0 after each repeat step.
                    w_step_up = (r_dir == DIR_UP);
                    w_step_dn = (r_dir == DIR_DN);
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            ST_BLOCK: begin
                if (!w_up && !w_dn) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Step pulses and counter: the pulse and the count change on one edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
            r_count   <= INIT;
        end else begin
            r_step_up <= w_step_up;
            r_step_dn <= w_step_dn;
            if (w_step_up) begin
                r_count <= r_count + WIDTH'(1);
            end else if (w_step_dn) begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Click request: every step (re)starts a full CLICK_CYCLES window.
    // ------------------------------------------------------------------
    assign w_step_any = w_step_up | w_step_dn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_click     <= 1'b0;
            r_click_cnt <= '0;
        end else if (w_step_any) begin
            r_click     <= 1'b1;
            r_click_cnt <= '0;
        end else if (r_click) begin
            if (r_click_cnt == KW'(CLICK_CYCLES - 1)) begin
                r_click     <= 1'b0;
                r_click_cnt <= '0;
            end else begin
                r_click_cnt <= r_click_cnt + KW'(1);
            end
        end
    end

    assign step_up   = r_step_up;
    assign step_dn   = r_step_dn;
    assign count     = r_count;
    assign click     = r_click;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_updown_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_updown_step_ctrl
//   Directed bench for updown_step_ctrl with shortened timing
//   (debounce 4, repeat delay 20, repeat period 5, click 3).
//   Cycle numbering: "cyc" advances on every rising edge; a stimulus change
//   made just after edge T reaches a step pulse on edge T+7.
// ----------------------------------------------------------------------------
module tb_updown_step_ctrl;
    import updown_step_ctrl_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int CK  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_up_n = 1'b1;
    logic        btn_dn_n = 1'b1;
    logic        step_up, step_dn, click;
    logic [15:0] count;
    state_t      dbg_state;

    logic        btn_up_f = 1'b1;
    logic        step_up_f, step_dn_f, click_f;
    logic [15:0] count_f;
    state_t      dbg_state_f;

    logic        btn_dn_z = 1'b1;
    logic        step_up_z, step_dn_z, click_z;
    logic [15:0] count_z;
    state_t      dbg_state_z;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int click_hi = 0;
    int both_hi = 0;
    int side_steps = 0;
    int side_clicks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] up_q[$];
    logic [31:0] dn_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    updown_step_ctrl #(
        .WIDTH(16), .INIT(16'h05ec), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CLICK_CYCLES(CK)
    ) u_dut (
        .clk(clk), .reset(reset), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .step_up(step_up), .step_dn(step_dn), .count(count), .click(click),
        .dbg_state(dbg_state)
    );

    updown_step_ctrl #(
        .WIDTH(16), .INIT(16'hffff), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CLICK_CYCLES(CK)
    ) u_dut_ff (
        .clk(clk), .reset(reset), .btn_up_n(btn_up_f), .btn_dn_n(1'b1),
        .step_up(step_up_f), .step_dn(step_dn_f), .count(count_f), .click(click_f),
        .dbg_state(dbg_state_f)
    );

    updown_step_ctrl #(
        .WIDTH(16), .INIT(16'h0000), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CLICK_CYCLES(CK)
    ) u_dut_00 (
        .clk(clk), .reset(reset), .btn_up_n(1'b1), .btn_dn_n(btn_dn_z),
        .step_up(step_up_z), .step_dn(step_dn_z), .count(count_z), .click(click_z),
        .dbg_state(dbg_state_z)
    );

    // ---------------- observation (mid-cycle, away from rising edge) ----------------
    always @(negedge clk) begin
        if (step_up) up_q.push_back(32'(cyc));
        if (step_dn) dn_q.push_back(32'(cyc));
        if (click) click_hi = click_hi + 1;
        if (step_up && step_dn) both_hi = both_hi + 1;
        if (step_up_f || step_dn_f || step_up_z || step_dn_z) side_steps = side_steps + 1;
        if (click_f || click_z) side_clicks = side_clicks + 1;
        if (dbg_state_f == ST_BLOCK || dbg_state_z == ST_BLOCK) both_hi = both_hi + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        up_q.delete();
        dn_q.delete();
        exp_q.delete();
        click_hi = 0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares the recorded step cycles of one direction against exp_q.
    task automatic compare_steps(input string tag, input bit is_dn);
        logic [31:0] e;
        logic [31:0] o;
        int n_obs;
        n_obs = is_dn ? dn_q.size() : up_q.size();
        check({tag, "_nsteps"}, 32'(n_obs), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (is_dn) begin
                if (dn_q.size() == 0) break;
                o = dn_q.pop_front();
            end else begin
                if (up_q.size() == 0) break;
                o = up_q.pop_front();
            end
            check({tag, "_cycle"}, o, e);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0;
        int tr;

        // Reset held
        tick(3);
        check("rst_count", 32'(count), 32'h05ec);
        check("rst_step_up", 32'(step_up), 32'd0);
        check("rst_step_dn", 32'(step_dn), 32'd0);
        check("rst_click", 32'(click), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_count_ff", 32'(count_f), 32'hffff);
        check("rst_count_00", 32'(count_z), 32'h0000);

        // 1. idle after reset release
        reset = 1'b1;
        clear_obs();
        tick(100);
        check("idle_up_steps", 32'(up_q.size()), 32'd0);
        check("idle_dn_steps", 32'(dn_q.size()), 32'd0);
        check("idle_click", 32'(click_hi), 32'd0);
        check("idle_count", 32'(count), 32'h05ec);

        // 2. clean 10-cycle press
        clear_obs();
        t0 = cyc;
        btn_up_n = 1'b0;
        tick(10);
        btn_up_n = 1'b1;
        tick(30);
        exp_q.push_back(32'(t0 + 7));
        compare_steps("single_up", 1'b0);
        check("single_no_dn", 32'(dn_q.size()), 32'd0);
        check("single_count", 32'(count), 32'h05ed);
        check("single_click_len", 32'(click_hi), 32'd3);
        check("single_state", 32'(dbg_state), 32'(ST_IDLE));

        // 3. bounce, then stable low
        clear_obs();
        btn_up_n = 1'b0; tick(2);
        btn_up_n = 1'b1; tick(2);
        btn_up_n = 1'b0; tick(2);
        btn_up_n = 1'b1; tick(2);
        t0 = cyc;
        btn_up_n = 1'b0;
        tick(15);
        btn_up_n = 1'b1;
        tick(30);
        exp_q.push_back(32'(t0 + 7));
        compare_steps("bounce_up", 1'b0);
        check("bounce_count", 32'(count), 32'h05ee);

        // 4. down held 60 cycles: delay, then repeat
        clear_obs();
        t0 = cyc;
        btn_dn_n = 1'b0;
        tick(60);
        btn_dn_n = 1'b1;
        tick(40);
        exp_q.push_back(32'(t0 + 7));
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(t0 + 27 + 5 * k));
        compare_steps("repeat_dn", 1'b1);
        check("repeat_no_up", 32'(up_q.size()), 32'd0);
        check("repeat_count", 32'(count), 32'h05e5);
        check("repeat_click_len", 32'(click_hi), 32'd27);
        check("repeat_state", 32'(dbg_state), 32'(ST_IDLE));

        // 5. wrap-around on the edge-value instances
        check("wrap_side_idle", 32'(side_steps), 32'd0);
        btn_up_f = 1'b0;
        tick(10);
        btn_up_f = 1'b1;
        tick(25);
        check("wrap_up_ffff", 32'(count_f), 32'h0000);
        btn_dn_z = 1'b0;
        tick(10);
        btn_dn_z = 1'b1;
        tick(25);
        check("wrap_dn_0000", 32'(count_z), 32'hffff);
        check("wrap_side_steps", 32'(side_steps), 32'd2);
        check("wrap_side_clicks", 32'(side_clicks), 32'd6);

        // 6. repeat interrupted by the other button
        clear_obs();
        t0 = cyc;
        btn_up_n = 1'b0;
        tick(34);
        check("blk_in_repeat", 32'(dbg_state), 32'(ST_REPEAT));
        btn_dn_n = 1'b0;
        tick(20);
        check("blk_state", 32'(dbg_state), 32'(ST_BLOCK));
        exp_q.push_back(32'(t0 + 7));
        exp_q.push_back(32'(t0 + 27));
        exp_q.push_back(32'(t0 + 32));
        exp_q.push_back(32'(t0 + 37));
        compare_steps("blk_up", 1'b0);
        btn_up_n = 1'b1;
        tick(30);
        check("blk_hold_dn_steps", 32'(up_q.size() + dn_q.size()), 32'd0);
        check("blk_hold_dn_state", 32'(dbg_state), 32'(ST_BLOCK));
        btn_dn_n = 1'b1;
        tick(30);
        check("blk_release_state", 32'(dbg_state), 32'(ST_IDLE));
        check("blk_release_steps", 32'(up_q.size() + dn_q.size()), 32'd0);
        check("blk_count", 32'(count), 32'h05e9);
        t0 = cyc;
        btn_up_n = 1'b0;
        tick(10);
        btn_up_n = 1'b1;
        tick(30);
        exp_q.push_back(32'(t0 + 7));
        compare_steps("after_blk_up", 1'b0);
        check("after_blk_count", 32'(count), 32'h05ea);

        // 6b. reset mid-repeat, button kept held through and after reset
        clear_obs();
        btn_up_n = 1'b0;
        tick(38);
        check("mid_click_before", 32'(click), 32'd1);
        check("mid_state_before", 32'(dbg_state), 32'(ST_REPEAT));
        reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'h05ec);
        check("mid_rst_click", 32'(click), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        tick(3);
        clear_obs();
        tr = cyc;
        reset = 1'b1;
        tick(15);
        btn_up_n = 1'b1;
        tick(30);
        exp_q.push_back(32'(tr + 7));
        compare_steps("post_rst_up", 1'b0);
        check("post_rst_count", 32'(count), 32'h05ed);

        check("never_both_steps", 32'(both_hi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
